// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decode/issue stage feeding the ALU. Decodes RV32I OP, OP-IMM,
//            LUI and AUIPC into a 4-bit ALU control code plus two operands
//            and queues the result in a 2-entry skid buffer, so in_ready
//            comes straight from the occupancy register.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid/in_ready/instr/pc      - upstream (fetch) handshake
//            rs1_addr/rs2_addr -> regfile, rs1_data/rs2_data <- regfile
//            out_valid/out_ready             - downstream (ALU) handshake
//            alu_ctrl, alu_in1, alu_in2, rd_addr, rd_we, illegal - head op
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [6:0] c_OP_OP    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [6:0] c_F7_BASE  = 7'b0000000;
    localparam logic [6:0] c_F7_ALT   = 7'b0100000;

    localparam logic [3:0] c_ADD  = 4'd0;
    localparam logic [3:0] c_SUB  = 4'd1;
    localparam logic [3:0] c_XOR  = 4'd2;
    localparam logic [3:0] c_OR   = 4'd3;
    localparam logic [3:0] c_AND  = 4'd4;
    localparam logic [3:0] c_SLL  = 4'd5;
    localparam logic [3:0] c_SRL  = 4'd6;
    localparam logic [3:0] c_SRA  = 4'd7;
    localparam logic [3:0] c_SLTU = 4'd8;
    localparam logic [3:0] c_SLT  = 4'd9;

    // Buffer occupancy states
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'(DEPTH);

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } entry_t;

    logic [1:0] r_count;
    logic [1:0] w_count_nxt;
    entry_t     r_ent0;     // head
    entry_t     r_ent1;     // second slot
    entry_t     w_dec;
    logic       w_legal;
    logic       w_accept;
    logic       w_pop;
    logic       w_load0;
    logic       w_load1;
    logic       w_shift;

    wire [6:0] w_opcode = instr[6:0];
    wire [2:0] w_f3     = instr[14:12];
    wire [6:0] w_f7     = instr[31:25];

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // Shared funct3 -> ALU code map for the base (funct7 = 0) encodings
    function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_ctrl = c_ADD;
            3'b001:  f3_ctrl = c_SLL;
            3'b010:  f3_ctrl = c_SLT;
            3'b011:  f3_ctrl = c_SLTU;
            3'b100:  f3_ctrl = c_XOR;
            3'b101:  f3_ctrl = c_SRL;
            3'b110:  f3_ctrl = c_OR;
            default: f3_ctrl = c_AND;
        endcase
    endfunction

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b0;
        w_dec.rd  = instr[11:7];
        case (w_opcode)
            c_OP_OP: begin
                w_dec.in1 = rs1_data;
                w_dec.in2 = rs2_data;
                if (w_f7 == c_F7_BASE) begin
                    w_legal    = 1'b1;
                    w_dec.ctrl = f3_ctrl(w_f3);
                end else if (w_f7 == c_F7_ALT && w_f3 == 3'b000) begin
                    w_legal    = 1'b1;
                    w_dec.ctrl = c_SUB;
                end else if (w_f7 == c_F7_ALT && w_f3 == 3'b101) begin
                    w_legal    = 1'b1;
                    w_dec.ctrl = c_SRA;
                end
            end
            c_OP_IMM: begin
                w_dec.in1 = rs1_data;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    // Shift-immediates carry a 5-bit shamt; funct7 selects SRL/SRA
                    w_dec.in2 = {27'b0, instr[24:20]};
                    if (w_f7 == c_F7_BASE) begin
                        w_legal    = 1'b1;
                        w_dec.ctrl = f3_ctrl(w_f3);
                    end else if (w_f7 == c_F7_ALT && w_f3 == 3'b101) begin
                        w_legal    = 1'b1;
                        w_dec.ctrl = c_SRA;
                    end
                end else begin
                    w_legal    = 1'b1;
                    w_dec.ctrl = f3_ctrl(w_f3);
                    w_dec.in2  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            c_OP_LUI: begin
                w_legal    = 1'b1;
                w_dec.ctrl = c_ADD;
                w_dec.in2  = {instr[31:12], 12'b0};
            end
            c_OP_AUIPC: begin
                w_legal    = 1'b1;
                w_dec.ctrl = c_ADD;
                w_dec.in1  = pc;
                w_dec.in2  = {instr[31:12], 12'b0};
            end
            default: w_legal = 1'b0;
        endcase
        // Undecodable ops travel as a harmless ADD 0,0 with writeback off
        if (!w_legal) begin
            w_dec.ctrl = c_ADD;
            w_dec.in1  = '0;
            w_dec.in2  = '0;
        end
        w_dec.ill = ~w_legal;
        w_dec.we  = w_legal && (instr[11:7] != 5'd0);
    end

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != c_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_count_nxt = r_count;
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_shift     = 1'b0;
        case (r_count)
            c_EMPTY: begin
                if (w_accept) begin
                    w_count_nxt = c_ONE;
                    w_load0     = 1'b1;
                end
            end
            c_ONE: begin
                if (w_accept && !w_pop) begin
                    w_count_nxt = c_FULL;
                    w_load1     = 1'b1;
                end else if (w_pop && !w_accept) begin
                    w_count_nxt = c_EMPTY;
                end else if (w_accept && w_pop) begin
                    w_load0     = 1'b1;
                end
            end
            c_FULL: begin
                if (w_pop) begin
                    w_count_nxt = c_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: w_count_nxt = c_EMPTY;
        endcase
        // Flush drops everything, including an op offered this very cycle
        if (flush) begin
            w_count_nxt = c_EMPTY;
            w_load0     = 1'b0;
            w_load1     = 1'b0;
            w_shift     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_EMPTY;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_load0) begin
                r_ent0 <= w_dec;
            end else if (w_shift) begin
                r_ent0 <= r_ent1;
            end
            if (w_load1) begin
                r_ent1 <= w_dec;
            end
        end
    end

    assign alu_ctrl = r_ent0.ctrl;
    assign alu_in1  = r_ent0.in1;
    assign alu_in2  = r_ent0.in2;
    assign rd_addr  = r_ent0.rd;
    assign rd_we    = r_ent0.we;
    assign illegal  = r_ent0.ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage. Directed cases for the
//            documented examples and corner cases, then randomized traffic
//            compared against a queue-based reference model each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    alu_issue_stage #(.XLEN(32), .DEPTH(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .pc       (pc),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_ctrl (alu_ctrl),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .rd_addr  (rd_addr),
        .rd_we    (rd_we),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        int unsigned rd;
        bit          we;
        bit          ill;
    } op_t;

    op_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules
    function automatic op_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
        int unsigned base_map [8] = '{0, 5, 9, 8, 2, 6, 3, 4};
        op_t e;
        int unsigned opc = ins[6:0];
        int unsigned f3  = ins[14:12];
        int unsigned f7  = ins[31:25];
        int unsigned shamt = ins[24:20];
        int signed   imm = $signed(ins) >>> 20;
        bit legal = 0;
        e.ctrl = 0; e.in1 = 0; e.in2 = 0;
        e.rd = ins[11:7];
        if (opc == 'h33) begin
            e.in1 = r1; e.in2 = r2;
            if (f7 == 0) begin legal = 1; e.ctrl = base_map[f3]; end
            else if (f7 == 'h20 && f3 == 0) begin legal = 1; e.ctrl = 1; end
            else if (f7 == 'h20 && f3 == 5) begin legal = 1; e.ctrl = 7; end
        end else if (opc == 'h13) begin
            e.in1 = r1;
            if (f3 == 1) begin legal = (f7 == 0); e.ctrl = 5; e.in2 = shamt; end
            else if (f3 == 5) begin
                legal = (f7 == 0) || (f7 == 'h20);
                e.ctrl = (f7 == 0) ? 6 : 7; e.in2 = shamt;
            end else begin legal = 1; e.ctrl = base_map[f3]; e.in2 = imm; end
        end else if (opc == 'h37) begin
            legal = 1; e.in2 = ins & 32'hFFFFF000;
        end else if (opc == 'h17) begin
            legal = 1; e.in1 = p; e.in2 = ins & 32'hFFFFF000;
        end
        if (!legal) begin e.ctrl = 0; e.in1 = 0; e.in2 = 0; end
        e.ill = !legal;
        e.we  = legal && (e.rd != 0);
        return e;
    endfunction

    // One clock of stimulus; model update; compare DUT against model after the edge
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl, input logic rs);
        bit acc;
        bit pp;
        in_valid = iv; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl; rst = rs;
        #1;
        chk("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
        chk("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
        if (rs || fl) begin
            q.delete();
        end else begin
            acc = iv && (q.size() < 2);
            pp  = ordy && (q.size() > 0);
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, p, r1, r2));
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("alu_ctrl", 32'(alu_ctrl), q[0].ctrl);
            chk("alu_in1",  alu_in1,       q[0].in1);
            chk("alu_in2",  alu_in2,       q[0].in2);
            chk("rd_addr",  32'(rd_addr),  q[0].rd);
            chk("rd_we",    32'(rd_we),    32'(q[0].we));
            chk("illegal",  32'(illegal),  32'(q[0].ill));
        end else if (rs) begin
            chk("rst_ctrl", 32'(alu_ctrl), 0);
            chk("rst_in1",  alu_in1,       0);
            chk("rst_in2",  alu_in2,       0);
            chk("rst_rd",   32'(rd_addr),  0);
            chk("rst_we",   32'(rd_we),    0);
            chk("rst_ill",  32'(illegal),  0);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        int unsigned kind = $urandom_range(0, 9);
        int unsigned sel  = $urandom_range(0, 4);
        logic [6:0]  f7   = (sel < 3) ? 7'h00 : (sel == 3) ? 7'h20 : 7'($urandom);
        if (kind <= 3)      ins = {f7, ins[24:7], 7'h33};
        else if (kind <= 6) ins = {((ins[13:12] == 2'b01) ? f7 : ins[31:25]), ins[24:7], 7'h13};
        else if (kind == 7) ins = {ins[31:7], 7'h37};
        else if (kind == 8) ins = {ins[31:7], 7'h17};
        return ins;
    endfunction

    localparam logic [31:0] c_ADDI1 = 32'h00100093;
    localparam logic [31:0] c_ADDI2 = 32'h00200113;
    localparam logic [31:0] c_ADDI3 = 32'h00300193;

    initial begin
        in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
        out_ready = 0; flush = 0; rst = 1;

        // Reset
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("reset_in_ready", 32'(in_ready), 1);

        // ADD x3,x1,x2
        step(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        chk("add_ctrl", 32'(alu_ctrl), 0);
        chk("add_in1", alu_in1, 5);
        chk("add_in2", alu_in2, 7);
        chk("add_rd", 32'(rd_addr), 3);
        chk("add_we", 32'(rd_we), 1);
        // SRAI x5,x6,4
        step(1'b1, 32'h40435293, 32'h104, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("srai_ctrl", 32'(alu_ctrl), 7);
        chk("srai_in1", alu_in1, 32'h80000000);
        chk("srai_in2", alu_in2, 4);
        chk("srai_rd", 32'(rd_addr), 5);
        // ADDI x1,x0,-1
        step(1'b1, 32'hFFF00093, 32'h108, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("addi_neg_in2", alu_in2, 32'hFFFFFFFF);
        // LUI x7,0x12345
        step(1'b1, 32'h123453B7, 32'h10C, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);
        chk("lui_in1", alu_in1, 0);
        chk("lui_in2", alu_in2, 32'h12345000);
        idle(1'b1);

        // Backpressure: three offers with out_ready low, then drain in order
        step(1'b1, c_ADDI1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADDI2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 0);
        step(1'b1, c_ADDI3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("held_head", alu_in2, 1);
        step(1'b1, c_ADDI3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_second", alu_in2, 2);
        step(1'b1, c_ADDI3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_third", alu_in2, 3);
        idle(1'b1);

        // Illegal encodings and x0 destination
        step(1'b1, 32'h00000000, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("zero_illegal", 32'(illegal), 1);
        chk("zero_we", 32'(rd_we), 0);
        step(1'b1, 32'h00208033, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("x0_we", 32'(rd_we), 0);
        step(1'b1, 32'h402091B3, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("sub_f3_illegal", 32'(illegal), 1);
        idle(1'b1);

        // Flush while full with a same-cycle offer
        step(1'b1, c_ADDI1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADDI2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADDI3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        idle(1'b1);
        chk("flush_no_ghost", 32'(out_valid), 0);

        // Reset while full
        step(1'b1, c_ADDI1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADDI2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c_ADDI3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
